// File: rtl/check_digit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : check_digit_pkg
//  Purpose  : Shared helper for the digit checker. The parent pre-inverts
//             every input bit where the target digit has a 1. A digit
//             therefore matches exactly when all four conditioned bits are 0.
//  Contents : digit_hit() - 4-input NOR of a conditioned nibble
//  Revision : 1.0  initial release
// ============================================================================
package check_digit_pkg;

  function automatic logic digit_hit(input logic [3:0] i_nib);
    return ~|i_nib;
  endfunction

endpackage
`default_nettype wire

// File: rtl/check_digit.sv
`default_nettype none
// ============================================================================
//  Module   : check_digit
//  Purpose  : Combinational 4-bit digit matcher with registered observers.
//             The observers are a delayed match, a rising-edge pulse, a run
//             counter that drives the stable flag, and a saturating count of
//             cycles in which the digit matched.
//  Ports    : match      out  combinational NOR(a,b,c,d)
//             a,b,c,d    in   pre-conditioned pattern bits (a = MSB)
//             clk        in   rising-edge clock
//             reset      in   synchronous active-high reset
//             match_q    out  match delayed by one cycle
//             rise       out  one-cycle pulse on a match_q 0->1 transition
//             stable     out  match seen STABLE_CYCLES consecutive cycles
//             match_cnt  out  saturating count of match-high cycles
//  Notes    : The first five ports keep their original order. This keeps
//             legacy positional instantiations (match, a, b, c, d) valid.
//  Revision : 1.0  initial release
// ============================================================================
module check_digit
  import check_digit_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int STABLE_CYCLES = 4
) (
  output logic             match,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             clk,
  input  logic             reset,
  output logic             match_q,
  output logic             rise,
  output logic             stable,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [CNT_W-1:0] c_STABLE  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  logic             w_match;
  logic             r_match_q;
  logic             r_rise;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_cnt;

  // The match path stays purely combinational and ignores clk and reset.
  assign w_match = digit_hit({a, b, c, d});
  assign match   = w_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_match_q <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_match_q <= w_match;
      // Compare against the old match_q. The pulse therefore lines up with
      // the cycle in which match_q first reads 1.
      r_rise    <= w_match & ~r_match_q;
    end
  end

  // Run length of the current match streak. It holds at STABLE_CYCLES and
  // does not keep counting, so it can never wrap back below the threshold.
  always_ff @(posedge clk) begin
    if (reset || !w_match) begin
      r_run <= '0;
    end else if (r_run != c_STABLE) begin
      r_run <= r_run + c_ONE;
    end
  end

  // Total match cycles. Only reset clears this counter; a non-match cycle
  // leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  assign match_q   = r_match_q;
  assign rise      = r_rise;
  assign stable    = (r_run == c_STABLE);
  assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_check_digit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_check_digit
//  Purpose  : Self-checking bench for check_digit. It uses two instances
//             that share their inputs:
//               - CNT_W=8, STABLE_CYCLES=4
//               - CNT_W=2, STABLE_CYCLES=3
//             It also uses a two-digit top-level pairing that decodes 8'h62.
//  Revision : 1.0  initial release
// ============================================================================
module tb_check_digit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic [7:0] sw = 8'h00;

  logic       match8, q8, rise8, stab8;
  logic [7:0] cnt8;
  logic       match2, q2, rise2, stab2;
  logic [1:0] cnt2;
  logic       mhi, mlo, uq_h, ur_h, us_h, uq_l, ur_l, us_l;
  logic [7:0] uc_h, uc_l;

  always #5 clk = ~clk;

  check_digit #(.CNT_W(8), .STABLE_CYCLES(4)) u_dut8 (
    .match(match8), .a(a), .b(b), .c(c), .d(d), .clk(clk), .reset(reset),
    .match_q(q8), .rise(rise8), .stable(stab8), .match_cnt(cnt8));

  check_digit #(.CNT_W(2), .STABLE_CYCLES(3)) u_dut2 (
    .match(match2), .a(a), .b(b), .c(c), .d(d), .clk(clk), .reset(reset),
    .match_q(q2), .rise(rise2), .stable(stab2), .match_cnt(cnt2));

  // Two-digit decoder for 8'h62: SW[6], SW[5] and SW[1] are pre-inverted.
  check_digit u_hi (
    .match(mhi), .a(sw[7]), .b(~sw[6]), .c(~sw[5]), .d(sw[4]), .clk(clk),
    .reset(reset), .match_q(uq_h), .rise(ur_h), .stable(us_h), .match_cnt(uc_h));

  check_digit u_lo (
    .match(mlo), .a(sw[3]), .b(sw[2]), .c(~sw[1]), .d(sw[0]), .clk(clk),
    .reset(reset), .match_q(uq_l), .rise(ur_l), .stable(us_l), .match_cnt(uc_l));

  typedef struct packed {
    logic [10:0] v8;   // {match_q, rise, stable, match_cnt[7:0]}
    logic [4:0]  v2;   // {match_q, rise, stable, match_cnt[1:0]}
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state, kept as plain integers.
  int m_q = 0, m_run8 = 0, m_cnt8 = 0, m_run2 = 0, m_cnt2 = 0, m_rise = 0;

  // Drive one cycle of stimulus at the falling edge. The expected registered
  // state after the next rising edge is pushed onto the scoreboard.
  task automatic drive(input logic [3:0] v, input logic r);
    int   mt;
    exp_t e;
    @(negedge clk);
    {a, b, c, d} = v;
    reset = r;
    mt = (v == 4'h0) ? 1 : 0;
    if (r) begin
      m_q = 0; m_rise = 0; m_run8 = 0; m_cnt8 = 0; m_run2 = 0; m_cnt2 = 0;
    end else begin
      m_rise = (mt == 1 && m_q == 0) ? 1 : 0;
      m_q    = mt;
      m_run8 = mt ? ((m_run8 + 1 > 4) ? 4 : m_run8 + 1) : 0;
      m_run2 = mt ? ((m_run2 + 1 > 3) ? 3 : m_run2 + 1) : 0;
      if (mt) begin
        m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
    end
    e.v8 = {m_q[0], m_rise[0], (m_run8 == 4), 8'(m_cnt8)};
    e.v2 = {m_q[0], m_rise[0], (m_run2 == 3), 2'(m_cnt2)};
    sb.push_back(e);
  endtask

  task automatic test_comb_sweep();
    reset = 1'b1;
    for (int v = 0; v < 16; v++) begin
      {a, b, c, d} = 4'(v);
      #10;
      total++;
      if (match8 !== (v == 0) || match2 !== (v == 0)) begin
        bad++;
        $display("FAIL comb_sweep abcd=%0d got=%b/%b exp=%b", v, match8, match2, (v == 0));
      end
    end
  endtask

  task automatic test_top_sweep();
    for (int v = 0; v < 256; v++) begin
      sw = 8'(v);
      #10;
      total++;
      if ((mhi & mlo) !== (v == 8'h62)) begin
        bad++;
        $display("FAIL top_sweep sw=%02h got=%b exp=%b", v, mhi & mlo, (v == 8'h62));
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if ({q8, rise8, stab8, cnt8} !== e.v8 || {q2, rise2, stab2, cnt2} !== e.v2 || match8 !== 1'b1) begin
        bad++;
        $display("FAIL reset got=%h/%h m=%b exp=%h/%h m=1", {q8, rise8, stab8, cnt8},
                 {q2, rise2, stab2, cnt2}, match8, e.v8, e.v2);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      drive(4'h0, 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if ({q8, rise8, stab8, cnt8} !== e.v8 || {q2, rise2, stab2, cnt2} !== e.v2) begin
        bad++;
        $display("FAIL hold cyc=%0d got=%h/%h exp=%h/%h", i + 1, {q8, rise8, stab8, cnt8},
                 {q2, rise2, stab2, cnt2}, e.v8, e.v2);
      end
    end
    total++;
    if (cnt8 !== 8'd6 || stab8 !== 1'b1 || cnt2 !== 2'd3) begin
      bad++;
      $display("FAIL hold_final cnt8=%0d stab8=%b cnt2=%0d exp 6/1/3", cnt8, stab8, cnt2);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   rises = 0;
    int   stabs = 0;
    drive(4'h1, 1'b1);
    @(posedge clk); #1;
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive((i == 0) ? 4'h0 : 4'h1, 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      rises += int'(rise8);
      stabs += int'(stab8) + int'(stab2);
      total++;
      if ({q8, rise8, stab8, cnt8} !== e.v8 || {q2, rise2, stab2, cnt2} !== e.v2) begin
        bad++;
        $display("FAIL glitch cyc=%0d got=%h/%h exp=%h/%h", i, {q8, rise8, stab8, cnt8},
                 {q2, rise2, stab2, cnt2}, e.v8, e.v2);
      end
    end
    total++;
    if (rises != 1 || stabs != 0 || cnt8 !== 8'd1) begin
      bad++;
      $display("FAIL glitch_summary rises=%0d stables=%0d cnt=%0d exp 1/0/1", rises, stabs, cnt8);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [3:0] v_seq[8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic       r_seq[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(v_seq[i], r_seq[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if ({q8, rise8, stab8, cnt8} !== e.v8 || {q2, rise2, stab2, cnt2} !== e.v2 || match8 !== 1'b1) begin
        bad++;
        $display("FAIL mid_reset cyc=%0d got=%h/%h m=%b exp=%h/%h m=1", i, {q8, rise8, stab8, cnt8},
                 {q2, rise2, stab2, cnt2}, match8, e.v8, e.v2);
      end
    end
  endtask

  // A long hold drives the 8-bit counter into saturation at 255.
  task automatic test_long_hold();
    exp_t e;
    drive(4'h0, 1'b1);
    @(posedge clk); #1;
    void'(sb.pop_front());
    for (int i = 0; i < 262; i++) begin
      drive(4'h0, 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      if (i >= 250) begin
        total++;
        if ({q8, rise8, stab8, cnt8} !== e.v8 || {q2, rise2, stab2, cnt2} !== e.v2) begin
          bad++;
          $display("FAIL long_hold cyc=%0d got=%h/%h exp=%h/%h", i + 1, {q8, rise8, stab8, cnt8},
                   {q2, rise2, stab2, cnt2}, e.v8, e.v2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [3:0] v;
    logic       r;
    drive(4'h5, 1'b1);
    @(posedge clk); #1;
    void'(sb.pop_front());
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 24) == 0);
      drive(v, r);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if ({q8, rise8, stab8, cnt8} !== e.v8 || {q2, rise2, stab2, cnt2} !== e.v2) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%h/%h exp=%h/%h", i, {q8, rise8, stab8, cnt8},
                 {q2, rise2, stab2, cnt2}, e.v8, e.v2);
      end
    end
  endtask

  initial begin
    test_comb_sweep();
    test_top_sweep();
    test_reset();
    test_hold();
    test_glitch();
    test_mid_reset();
    test_long_hold();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
